// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states and access sizing.
package lsu_pkg;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h1;
    localparam logic [3:0] OP_LH   = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_LBU  = 4'h4;
    localparam logic [3:0] OP_LHU  = 4'h5;
    localparam logic [3:0] OP_SB   = 4'h6;
    localparam logic [3:0] OP_SH   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;

    typedef enum logic {IDLE, BUSY} state_e;

    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    function automatic size_e op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store replication and byte enables, misalign check,
// and load lane extraction with sign/zero extension.
module lsu_lane_align import lsu_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    localparam int NLANE = DATA_WIDTH / 8,
    localparam int OFFW  = $clog2(NLANE)
) (
    input  logic [3:0]            st_op_i,
    input  logic [OFFW-1:0]       st_off_i,
    input  logic [31:0]           st_data_i,
    output logic [NLANE-1:0]      st_be_o,
    output logic [DATA_WIDTH-1:0] st_data_o,
    output logic                  misalign_o,
    input  logic [3:0]            ld_op_i,
    input  logic [OFFW-1:0]       ld_off_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    output logic [31:0]           ld_data_o
);

    localparam int SELW = $clog2(DATA_WIDTH + 24);

    size_e                  st_sz;
    logic [DATA_WIDTH+23:0] ld_ext;
    logic [SELW-1:0]        ld_sel;
    logic [31:0]            lane;
    logic signed [7:0]      lane_b_s;
    logic signed [15:0]     lane_h_s;

    assign st_sz = op_size(st_op_i);

    always_comb begin
        st_be_o    = '0;
        st_data_o  = '0;
        misalign_o = 1'b0;
        case (st_sz)
            SZ_BYTE: begin
                st_be_o   = NLANE'(1) << st_off_i;
                st_data_o = {NLANE{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = NLANE'(3) << st_off_i;
                st_data_o  = {(NLANE/2){st_data_i[15:0]}};
                misalign_o = st_off_i[0];
            end
            SZ_WORD: begin
                st_be_o    = NLANE'(15) << st_off_i;
                st_data_o  = {(NLANE/4){st_data_i}};
                misalign_o = |st_off_i[1:0];
            end
            default: ;
        endcase
    end

    // Zero padding above the bus keeps the 32-bit window in range for every offset.
    assign ld_ext   = {24'h0, ld_data_i};
    assign ld_sel   = SELW'({ld_off_i, 3'b000});
    assign lane     = ld_ext[ld_sel +: 32];
    assign lane_b_s = lane[7:0];
    assign lane_h_s = lane[15:0];

    always_comb begin
        case (ld_op_i)
            OP_LB:   ld_data_o = 32'(lane_b_s);
            OP_LH:   ld_data_o = 32'(lane_h_s);
            OP_LBU:  ld_data_o = {24'h0, lane[7:0]};
            OP_LHU:  ld_data_o = {16'h0, lane[15:0]};
            default: ld_data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: IDLE/BUSY handshake FSM to RAM with timeout, misalign trap,
// registered write-back beat and sticky halt flag.
module mem_lsu import lsu_pkg::*; #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    RADDR_WIDTH    = 5,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = 32'h0000_1000,
    parameter int                    TIMEOUT_CYCLES = 255,
    localparam int NLANE = DATA_WIDTH / 8,
    localparam int OFFW  = $clog2(NLANE)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic [3:0]             mem_op_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [31:0]            mem_data_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [31:0]            reg_wdata_i,
    output logic                   stall_o,
    output logic                   ram_req_o,
    output logic                   ram_we_o,
    output logic [ADDR_WIDTH-1:0]  ram_addr_o,
    output logic [NLANE-1:0]       ram_be_o,
    output logic [DATA_WIDTH-1:0]  ram_data_o,
    input  logic                   ram_ack_i,
    input  logic [DATA_WIDTH-1:0]  ram_data_i,
    output logic                   wb_valid_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [31:0]            reg_wdata_o,
    output logic                   misalign_o,
    output logic                   bus_err_o,
    output logic                   halt_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state_q;
    logic [3:0]             op_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [RADDR_WIDTH-1:0] raddr_q;
    logic                   we_q;
    logic [31:0]            wdata_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ram_req_q, ram_we_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic [NLANE-1:0]       ram_be_q;
    logic [DATA_WIDTH-1:0]  ram_data_q;
    logic                   wb_valid_q, misalign_q, bus_err_q, halt_q;
    logic [RADDR_WIDTH-1:0] reg_waddr_q;
    logic                   reg_we_q;
    logic [31:0]            reg_wdata_q;

    logic                   is_mem, req_misalign, timeout;
    logic [NLANE-1:0]       st_be;
    logic [DATA_WIDTH-1:0]  st_data;
    logic [31:0]            ld_data;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_op_i    (mem_op_i),
        .st_off_i   (mem_addr_i[OFFW-1:0]),
        .st_data_i  (mem_data_i),
        .st_be_o    (st_be),
        .st_data_o  (st_data),
        .misalign_o (req_misalign),
        .ld_op_i    (op_q),
        .ld_off_i   (addr_q[OFFW-1:0]),
        .ld_data_i  (ram_data_i),
        .ld_data_o  (ld_data)
    );

    assign is_mem  = (op_size(mem_op_i) != SZ_NONE);
    // Counter holds the number of BUSY cycles already spent; this cycle is the last allowed.
    assign timeout = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stall_o = ((state_q == IDLE) && req_valid_i && is_mem && !req_misalign) ||
                     ((state_q == BUSY) && !ram_ack_i && !timeout);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= OP_NONE;
            addr_q      <= '0;
            raddr_q     <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_data_q  <= '0;
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            halt_q      <= 1'b0;
            reg_waddr_q <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: if (req_valid_i) begin
                    op_q    <= mem_op_i;
                    addr_q  <= mem_addr_i;
                    raddr_q <= reg_waddr_i;
                    we_q    <= reg_we_i;
                    wdata_q <= reg_wdata_i;
                    if (!is_mem || req_misalign) begin
                        wb_valid_q  <= 1'b1;
                        misalign_q  <= is_mem;
                        reg_waddr_q <= reg_waddr_i;
                        reg_we_q    <= reg_we_i && !is_mem;
                        reg_wdata_q <= reg_wdata_i;
                    end else begin
                        state_q    <= BUSY;
                        cnt_q      <= '0;
                        ram_req_q  <= 1'b1;
                        ram_we_q   <= op_is_store(mem_op_i);
                        ram_addr_q <= {mem_addr_i[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                        ram_be_q   <= op_is_store(mem_op_i) ? st_be : '1;
                        ram_data_q <= st_data;
                    end
                end
                BUSY: begin
                    if (ram_ack_i || timeout) begin
                        state_q     <= IDLE;
                        ram_req_q   <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        reg_waddr_q <= raddr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Ack takes priority over a coincident timeout.
                    if (ram_ack_i) begin
                        reg_we_q    <= we_q && !op_is_store(op_q);
                        reg_wdata_q <= op_is_store(op_q) ? wdata_q : ld_data;
                        if (op_q == OP_SW && addr_q == HALT_ADDR) halt_q <= 1'b1;
                    end else if (timeout) begin
                        bus_err_q   <= 1'b1;
                        reg_we_q    <= 1'b0;
                        reg_wdata_q <= wdata_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_req_o   = ram_req_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_be_o    = ram_be_q;
    assign ram_data_o  = ram_data_q;
    assign wb_valid_o  = wb_valid_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
    assign halt_o      = halt_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = reg_we_q;
    assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: 32-bit instance plus a 64-bit instance sharing the request side.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, reg_we, ram_ack;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_data, reg_wdata, ram_rdata;
    logic [4:0]  reg_waddr;

    logic        stall, ram_req, ram_we, wb_valid, wb_we, misalign, bus_err, halt;
    logic [31:0] ram_addr, ram_wdata, wb_wdata;
    logic [3:0]  ram_be;
    logic [4:0]  wb_waddr;

    logic        s64_stall, s64_req, s64_we, s64_wbv, s64_wbwe, s64_mis, s64_berr, s64_halt;
    logic [31:0] s64_addr, s64_wbdata;
    logic [63:0] s64_wdata;
    logic [7:0]  s64_be;
    logic [4:0]  s64_wbaddr;

    int n_checks = 0;
    int n_errors = 0;

    mem_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .mem_op_i(mem_op),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .reg_waddr_i(reg_waddr),
        .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .stall_o(stall),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_be_o(ram_be),
        .ram_data_o(ram_wdata), .ram_ack_i(ram_ack), .ram_data_i(ram_rdata),
        .wb_valid_o(wb_valid), .reg_waddr_o(wb_waddr), .reg_we_o(wb_we),
        .reg_wdata_o(wb_wdata), .misalign_o(misalign), .bus_err_o(bus_err), .halt_o(halt)
    );

    mem_lsu #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(4)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .mem_op_i(mem_op),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .reg_waddr_i(reg_waddr),
        .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .stall_o(s64_stall),
        .ram_req_o(s64_req), .ram_we_o(s64_we), .ram_addr_o(s64_addr), .ram_be_o(s64_be),
        .ram_data_o(s64_wdata), .ram_ack_i(ram_ack), .ram_data_i({ram_rdata, ram_rdata}),
        .wb_valid_o(s64_wbv), .reg_waddr_o(s64_wbaddr), .reg_we_o(s64_wbwe),
        .reg_wdata_o(s64_wbdata), .misalign_o(s64_mis), .bus_err_o(s64_berr), .halt_o(s64_halt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
        req_valid = 1'b1;
        mem_op    = op;
        mem_addr  = addr;
        mem_data  = sd;
        reg_waddr = 5'd7;
        reg_we    = 1'b1;
        reg_wdata = 32'h5555_AAAA;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        mem_op    = OP_NONE;
        #1;
    endtask

    localparam logic [31:0] RAM_WORD = 32'h80FF_7F01;
    logic [3:0]  lop  [5] = '{OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB};
    logic [31:0] ladr [5] = '{32'h103, 32'h102, 32'h100, 32'h100, 32'h101};
    logic [31:0] lexp [5] = '{32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01, 32'h0000_007F};

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_op = OP_NONE; mem_addr = '0; mem_data = '0;
        reg_waddr = '0; reg_we = 1'b0; reg_wdata = '0; ram_ack = 1'b0; ram_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_req", ram_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_halt", halt, 0);
        check("rst_be", ram_be, 0);
        check("rst_wdata", wb_wdata, 0);
        rst = 1'b0;

        // LB at 0x102 with ack in the second BUSY cycle
        @(negedge clk); req(OP_LB, 32'h102, 32'h0);
        check("lb_stall_acc", stall, 1);
        @(negedge clk); idle();
        check("lb_req", ram_req, 1);
        check("lb_addr", ram_addr, 32'h100);
        check("lb_be", ram_be, 4'hF);
        check("lb_we", ram_we, 0);
        check("lb_stall_busy", stall, 1);
        @(negedge clk); ram_ack = 1'b1; ram_rdata = RAM_WORD; #1;
        check("lb_stall_ack", stall, 0);
        check("lb_wbv_early", wb_valid, 0);
        @(negedge clk); ram_ack = 1'b0; #1;
        check("lb_wbv", wb_valid, 1);
        check("lb_data", wb_wdata, 32'hFFFF_FFFF);
        check("lb_we_o", wb_we, 1);
        check("lb_waddr", wb_waddr, 7);
        check("lb_req_drop", ram_req, 0);

        // Back-to-back zero-wait loads, one access every two cycles
        for (int i = 0; i < 5; i++) begin
            req(lop[i], ladr[i], 32'h0);
            check("ld_stall_acc", stall, 1);
            @(negedge clk); idle(); ram_ack = 1'b1; ram_rdata = RAM_WORD; #1;
            check("ld_stall_ack", stall, 0);
            @(negedge clk); ram_ack = 1'b0; #1;
            check("ld_wbv", wb_valid, 1);
            check("ld_data", wb_wdata, lexp[i]);
        end
        idle();

        // SH at 0x206 on both bus widths
        req(OP_SH, 32'h206, 32'hDEAD_1234);
        @(negedge clk); idle();
        check("sh_be32", ram_be, 4'b1100);
        check("sh_data32", ram_wdata, 32'h1234_1234);
        check("sh_addr32", ram_addr, 32'h204);
        check("sh_we32", ram_we, 1);
        check("sh_be64", s64_be, 8'b1100_0000);
        check("sh_data64", s64_wdata, 64'h1234_1234_1234_1234);
        check("sh_addr64", s64_addr, 32'h200);
        ram_ack = 1'b1;
        @(negedge clk); ram_ack = 1'b0; #1;
        check("sh_wbv", wb_valid, 1);
        check("sh_reg_we", wb_we, 0);

        // SB at 0x203, SW at 0x208 (not the halt address)
        req(OP_SB, 32'h203, 32'h0000_00AB);
        @(negedge clk); idle();
        check("sb_be", ram_be, 4'b1000);
        check("sb_data", ram_wdata, 32'hABAB_ABAB);
        ram_ack = 1'b1;
        @(negedge clk); ram_ack = 1'b0;
        req(OP_SW, 32'h208, 32'h0BAD_F00D);
        @(negedge clk); idle();
        check("sw_be", ram_be, 4'hF);
        check("sw_data", ram_wdata, 32'h0BAD_F00D);
        ram_ack = 1'b1;
        @(negedge clk); ram_ack = 1'b0; #1;
        check("sw_nohalt", halt, 0);

        // NONE pass-through
        req_valid = 1'b1; mem_op = OP_NONE; reg_waddr = 5'd9; reg_we = 1'b1; reg_wdata = 32'hCAFE_F00D; #1;
        check("none_stall", stall, 0);
        @(negedge clk); idle();
        check("none_wbv", wb_valid, 1);
        check("none_waddr", wb_waddr, 9);
        check("none_we", wb_we, 1);
        check("none_data", wb_wdata, 32'hCAFE_F00D);

        // Misaligned LW
        req(OP_LW, 32'h301, 32'h0);
        check("mis_stall", stall, 0);
        @(negedge clk); idle();
        check("mis_req", ram_req, 0);
        check("mis_wbv", wb_valid, 1);
        check("mis_flag", misalign, 1);
        check("mis_we", wb_we, 0);
        @(negedge clk);
        check("mis_pulse", misalign, 0);
        check("mis_req2", ram_req, 0);

        // Timeout after 4 BUSY cycles with no ack
        req(OP_LW, 32'h400, 32'h0);
        @(negedge clk); idle();
        check("to_stall1", stall, 1);
        repeat (2) @(negedge clk);
        check("to_stall3", stall, 1);
        check("to_berr_early", bus_err, 0);
        @(negedge clk);
        check("to_stall4", stall, 0);
        @(negedge clk);
        check("to_berr", bus_err, 1);
        check("to_wbv", wb_valid, 1);
        check("to_we", wb_we, 0);
        check("to_req", ram_req, 0);
        req(OP_NONE, 32'h0, 32'h0);
        @(negedge clk); idle();
        check("to_next_wbv", wb_valid, 1);
        check("to_berr_pulse", bus_err, 0);

        // Halt on acked SW to the halt address
        req(OP_SW, 32'h1000, 32'hFFFF_FFFF);
        @(negedge clk); idle(); ram_ack = 1'b1; #1;
        check("halt_pre", halt, 0);
        @(negedge clk); ram_ack = 1'b0; #1;
        check("halt_set", halt, 1);
        check("halt_wbv", wb_valid, 1);
        req(OP_NONE, 32'h0, 32'h0);
        @(negedge clk); idle();
        check("halt_hold1", halt, 1);
        @(negedge clk);
        check("halt_hold2", halt, 1);

        // Reset while BUSY, then a stale ack
        req(OP_LW, 32'h500, 32'h0);
        @(negedge clk); idle();
        check("rb_req", ram_req, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h1111_2222; #1;
        check("rb_req_low", ram_req, 0);
        check("rb_halt_clr", halt, 0);
        @(negedge clk); ram_ack = 1'b0; #1;
        check("rb_wbv", wb_valid, 0);
        check("rb_data", wb_wdata, 0);
        check("rb_stall", stall, 0);
        req(OP_NONE, 32'h0, 32'h0);
        @(negedge clk); idle();
        check("rb_idle_accept", wb_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit replacing the single-cycle MEM stage between `exe_mem` and `mem_wb`. Talks to RAM over a req/ack handshake with variable latency, uses byte enables instead of read-modify-write, and traps misaligned accesses and bus timeouts. Stalls the pipeline while an access is outstanding and presents one registered write-back beat per accepted request.

## Interface
Parameters:
- `DATA_WIDTH`, 32, RAM bus width; 32 or 64. `NLANE = DATA_WIDTH/8`, `OFFW = log2(NLANE)`.
- `ADDR_WIDTH`, 32, byte address width.
- `RADDR_WIDTH`, 5, register index width. Register data is fixed at 32 bits.
- `HALT_ADDR`, 32'h0000_1000, address whose completed `SW` raises `halt_o`.
- `TIMEOUT_CYCLES`, 255, maximum number of BUSY cycles without ack before the access is aborted.

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request from `exe_mem` is valid.
- `mem_op_i` in 4: LB/LH/LW/LBU/LHU/SB/SH/SW/NONE, coded as in `defines.v`.
- `mem_addr_i` in ADDR_WIDTH: byte address.
- `mem_data_i` in 32: store data.
- `reg_waddr_i` in RADDR_WIDTH, `reg_we_i` in 1, `reg_wdata_i` in 32: pass-through write-back.
- `stall_o` out 1: upstream holds its inputs and does not advance.
- `ram_req_o` out 1, `ram_we_o` out 1, `ram_addr_o` out ADDR_WIDTH, `ram_be_o` out NLANE, `ram_data_o` out DATA_WIDTH: RAM request.
- `ram_ack_i` in 1, `ram_data_i` in DATA_WIDTH: RAM completion and read data, valid in the ack cycle.
- `wb_valid_o` out 1, `reg_waddr_o` out RADDR_WIDTH, `reg_we_o` out 1, `reg_wdata_o` out 32: to `mem_wb`.
- `misalign_o` out 1, `bus_err_o` out 1: one-cycle exception pulses, aligned with `wb_valid_o`.
- `halt_o` out 1: sticky halt flag.

## Operation
- Two-state FSM, IDLE and BUSY. Inputs are sampled only in IDLE with `req_valid_i=1`.
- **IDLE, op NONE:** register the pass-through fields. Next cycle, `wb_valid_o=1` and `reg_w*_o` equal the inputs. No stall.
- **IDLE, misaligned memory op:** LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`. No RAM access and no stall. Next cycle, `wb_valid_o=1`, `misalign_o=1`, `reg_we_o=0`.
- **IDLE, aligned memory op:** latch the request, go to BUSY, and drive `stall_o=1` in this cycle.
  - `ram_addr_o = addr` with the low OFFW bits zeroed. `off = addr[OFFW-1:0]`.
  - Loads: `ram_we_o=0`, `ram_be_o` all ones.
  - Store data is replicated across lanes (byte, half, or word).
  - Store byte enables: SB gives `be = 1<<off`; SH gives `be = 2'b11<<off`; SW gives `be = 4'hF<<off`.
- **BUSY:**
  - `ram_req_o=1`; all `ram_*_o` are held stable.
  - The timeout counter increments each cycle.
  - `stall_o = !ram_ack_i && !timeout`.
- **BUSY, on `ram_ack_i`:** return to IDLE and drop `ram_req_o`. Next cycle, `wb_valid_o=1`.
  - Loads: `reg_wdata_o` is the lane at `off`, sign-extended (LB/LH) or zero-extended (LBU/LHU). LW returns the 32-bit lane.
  - Stores: `reg_we_o=0`.
- **Timeout:** counter reaches TIMEOUT_CYCLES with no ack. Abort, return to IDLE. Next cycle, `wb_valid_o=1`, `bus_err_o=1`, `reg_we_o=0`.
  - Ack and timeout in the same cycle: ack wins.
- **Halt:** an acked SW to HALT_ADDR sets `halt_o` on the write-back cycle. It clears only on reset.
- `ram_ack_i` outside BUSY is ignored.

## Timing
- Reset values: every output is 0, state is IDLE, the counter is 0, and `halt_o` is 0.
- Reset asserted while BUSY:
  - `ram_req_o` is low from the next cycle.
  - A later stale ack is ignored.
  - No write-back is produced.
- Latency:
  - Non-memory or misaligned op: write-back 1 cycle after acceptance.
  - Memory op acked N cycles into BUSY (N≥1): write-back N+1 cycles after acceptance.
  - Back-to-back zero-wait loads sustain 1 access per 2 cycles.
- `wb_valid_o`, `misalign_o` and `bus_err_o` are single-cycle pulses. `reg_*_o` hold their values until the next write-back.
- The timeout counter resets on every entry to BUSY.

## Structure
- Shared package `lsu_pkg` holds:
  - op codes, mirroring `defines.v`
  - the state enum `{IDLE, BUSY}`
  - a function giving the access size for each op
- One combinational sub-module, `lsu_lane_align`, handles store replication, byte-enable generation, load lane extract and extension, and the misalign check. It is parametrised by DATA_WIDTH.
- The top level holds the FSM, request latch, timeout counter, write-back registers and halt flag.

## Test plan
- **LB sign-extension:** DW=32, RAM word 0x80FF_7F01, LB at addr 0x102 with 2-cycle ack. Expect `reg_wdata_o=0xFFFF_FFFF` and `wb_valid_o` 3 cycles after acceptance. LBU at 0x103 gives 0x0000_0080.
- **SH byte enables:** SH data 0x1234 at 0x206. Expect `ram_be_o=4'b1100`, `ram_data_o=0x1234_1234`, `ram_addr_o=0x204`, `reg_we_o=0`. With DW=64, expect `be=8'b1100_0000`.
- **Misaligned load:** LW at 0x301. Expect `ram_req_o` never rises, `misalign_o=1` with `wb_valid_o` next cycle, `reg_we_o=0`.
- **Timeout:** TIMEOUT_CYCLES=4 and ack never returns. Expect `bus_err_o` pulse, `stall_o` low after 4 BUSY cycles, and the next request accepted.
- **Reset mid-access:** reset in BUSY, then a stale ack. Expect outputs at 0, no `wb_valid_o`, FSM in IDLE.
- **Halt:** SW to HALT_ADDR acked. Expect `halt_o=1`, holding through subsequent NONE ops; cleared only by `rst_i`.
